alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single registered 32-bit ALU between two requesters (e.g. execute stage and address/branch unit). It accepts one operation at a time over valid/ready handshakes and drives the ALU's operand and function inputs. It then captures the registered ALU result one clock later and returns result and status to the originating requester over a response handshake.

---
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter: operation requests in, responses out.
// The master modport is the requester side, the slave modport is the arbiter.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   // Valid/ready: a transfer happens on a rising Clock edge where both valid and
   // ready are high; valid never waits on ready, and payload is sampled only then.
   logic [1:0]       ReqValid;
   logic [1:0]       ReqReady;
   logic [WIDTH-1:0] ReqA0;
   logic [WIDTH-1:0] ReqB0;
   logic [2:0]       ReqF0;
   logic [WIDTH-1:0] ReqA1;
   logic [WIDTH-1:0] ReqB1;
   logic [2:0]       ReqF1;
   logic [1:0]       RspValid;
   logic [1:0]       RspReady;
   logic [WIDTH-1:0] RspResult;
   logic [3:0]       RspStatus;

   modport master (
      output ReqValid, ReqA0, ReqB0, ReqF0, ReqA1, ReqB1, ReqF1, RspReady,
      input  ReqReady, RspValid, RspResult, RspStatus
   );

   modport slave (
      input  ReqValid, ReqA0, ReqB0, ReqF0, ReqA1, ReqB1, ReqF1, RspReady,
      output ReqReady, RspValid, RspResult, RspStatus
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one registered ALU between two requesters:
// accept -> ISSUE -> CAPTURE -> RESP, one operation in flight at a time.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             ResetN,
   alu_arbiter_if.slave     bus,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic [2:0]       AluFunc,
   input  logic [WIDTH-1:0] AluResult,
   input  logic [3:0]       AluStatus,
   output logic             Busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             owner;
   logic             last_grant;
   logic             grant;
   logic             grant_vld;
   logic             accept;
   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_status;

   // Single requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = 1'b0;
      case (bus.ReqValid)
         2'b01: begin
            grant_vld = 1'b1;
            grant     = 1'b0;
         end
         2'b10: begin
            grant_vld = 1'b1;
            grant     = 1'b1;
         end
         2'b11: begin
            grant_vld = 1'b1;
            grant     = ~last_grant;
         end
         default: begin
            grant_vld = 1'b0;
            grant     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      accept    = 1'b0;
      rsp_valid = 2'b00;
      case (state)
         IDLE: begin
            // Ready is held low while reset is asserted even though state reads IDLE.
            if (grant_vld && ResetN) begin
               req_ready[grant] = 1'b1;
               accept           = 1'b1;
               state_nxt        = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (bus.RspReady[owner]) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         AluA       <= '0;
         AluB       <= '0;
         AluFunc    <= 3'b000;
      end else if (accept) begin
         owner      <= grant;
         last_grant <= grant;
         AluA       <= grant ? bus.ReqA1 : bus.ReqA0;
         AluB       <= grant ? bus.ReqB1 : bus.ReqB0;
         AluFunc    <= grant ? bus.ReqF1 : bus.ReqF0;
      end
   end

   // The ALU status register only tracks add/sub; its value is stale for other codes.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         rsp_result <= '0;
         rsp_status <= 4'b0000;
      end else if (state == CAPTURE) begin
         rsp_result <= AluResult;
         case (AluFunc)
            3'b000, 3'b001: rsp_status <= AluStatus;
            default:        rsp_status <= 4'b0000;
         endcase
      end
   end

   assign bus.ReqReady  = req_ready;
   assign bus.RspValid  = rsp_valid;
   assign bus.RspResult = rsp_result;
   assign bus.RspStatus = rsp_status;
   assign Busy          = (state != IDLE);
   assign dbg_state     = state;

   a_req_ready_onehot: assert property (
      @(posedge Clock) disable iff (!ResetN) $onehot0(bus.ReqReady));

   a_rsp_valid_onehot: assert property (
      @(posedge Clock) disable iff (!ResetN) $onehot0(bus.RspValid));

   a_rsp_hold: assert property (
      @(posedge Clock) disable iff (!ResetN)
      (state == RESP && !bus.RspReady[owner]) |=> (state == RESP && $stable(rsp_result)
                                                   && $stable(rsp_status)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a behavioural ALU, a round-robin grant
// model and an expected-response queue.
module tb_alu_arbiter;

   localparam int W = 32;

   logic         Clock;
   logic         ResetN;
   logic [W-1:0] AluA;
   logic [W-1:0] AluB;
   logic [2:0]   AluFunc;
   logic [W-1:0] AluResult;
   logic [3:0]   AluStatus;
   logic         Busy;
   logic [1:0]   dbg_state;
   logic [35:0]  alu_n;

   int           n_checks;
   int           n_errors;
   logic         model_last;
   logic [63:0]  t_accept;
   logic [35:0]  exp_q[$];

   alu_arbiter_if #(.WIDTH(W)) bus ();

   alu_arbiter #(.WIDTH(W)) dut (
      .Clock     (Clock),
      .ResetN    (ResetN),
      .bus       (bus),
      .AluA      (AluA),
      .AluB      (AluB),
      .AluFunc   (AluFunc),
      .AluResult (AluResult),
      .AluStatus (AluStatus),
      .Busy      (Busy),
      .dbg_state (dbg_state)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference ALU: {Over, Carry, Zero, Neg, result}.
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
      logic [32:0] w;
      logic [31:0] r;
      logic        ov;
      logic        cy;
      w  = '0;
      ov = 1'b0;
      cy = 1'b0;
      case (f)
         3'd0: begin
            w  = {1'b0, a} + {1'b0, b};
            r  = w[31:0];
            cy = w[32];
            ov = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd1: begin
            w  = {1'b0, a} - {1'b0, b};
            r  = w[31:0];
            cy = w[32];
            ov = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a ^ b;
         3'd5:    r = a << b[4:0];
         3'd6:    r = a >> b[4:0];
         default: r = $signed(a) >>> b[4:0];
      endcase
      return {ov, cy, (r == 32'd0), r[31], r};
   endfunction

   always_comb alu_n = alu_fn(AluA, AluB, AluFunc);

   always @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         AluResult <= '0;
         AluStatus <= 4'b0000;
      end else begin
         AluResult <= alu_n[31:0];
         if (AluFunc <= 3'd1) AluStatus <= alu_n[35:32];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f);
      if (r == 0) begin
         bus.ReqA0 = a;
         bus.ReqB0 = b;
         bus.ReqF0 = f;
      end else begin
         bus.ReqA1 = a;
         bus.ReqB1 = b;
         bus.ReqF1 = f;
      end
   endtask

   task automatic scramble();
      set_ops(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
      set_ops(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
   endtask

   // Starts in an IDLE cycle before the rising edge; ends in the IDLE cycle after release.
   task automatic do_op(input logic [1:0] vmask, input bit hold, input int bp,
                        input bit hold_ready);
      logic        g;
      logic [1:0]  ev;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [2:0]  ef;
      logic [35:0] m;
      logic [35:0] q;
      int          lat;
      bit          bad_ready;
      bus.ReqValid = vmask;
      bus.RspReady = hold_ready ? 2'b11 : 2'b00;
      #1;
      g  = (vmask == 2'b11) ? ~model_last : vmask[1];
      ev = g ? 2'b10 : 2'b01;
      check("req_ready", 64'(bus.ReqReady), 64'(ev));
      ea = g ? bus.ReqA1 : bus.ReqA0;
      eb = g ? bus.ReqB1 : bus.ReqB0;
      ef = g ? bus.ReqF1 : bus.ReqF0;
      m  = alu_fn(ea, eb, ef);
      if (ef > 3'd1) m[35:32] = 4'b0000;
      @(posedge Clock);
      t_accept   = $time;
      model_last = g;
      exp_q.push_back(m);
      #1;
      if (!hold) bus.ReqValid = 2'b00;
      scramble();
      lat       = 0;
      bad_ready = 1'b0;
      do begin
         @(negedge Clock);
         lat++;
         if (bus.ReqReady != 2'b00) bad_ready = 1'b1;
      end while (bus.RspValid == 2'b00 && lat < 10);
      check("rsp_latency", 64'(lat), 64'd3);
      check("rsp_valid", 64'(bus.RspValid), 64'(ev));
      check("sb_pending", 64'(exp_q.size()), 64'd1);
      q = (exp_q.size() != 0) ? exp_q.pop_front() : 36'h0;
      check("rsp_result", 64'(bus.RspResult), 64'(q[31:0]));
      check("rsp_status", 64'(bus.RspStatus), 64'(q[35:32]));
      check("busy", 64'(Busy), 64'd1);
      if (!hold_ready) begin
         for (int i = 0; i < bp; i++) begin
            bus.RspReady = ~ev;
            @(negedge Clock);
            if (bus.ReqReady != 2'b00) bad_ready = 1'b1;
            check("bp_valid", 64'(bus.RspValid), 64'(ev));
            check("bp_result", 64'(bus.RspResult), 64'(q[31:0]));
         end
      end
      check("req_ready_busy", 64'(bad_ready), 64'd0);
      bus.RspReady = hold_ready ? 2'b11 : ev;
      @(negedge Clock);
      check("rsp_release", 64'(bus.RspValid), 64'd0);
      check("alu_hold_a", 64'(AluA), 64'(ea));
      check("alu_hold_f", 64'(AluFunc), 64'(ef));
      if (!hold_ready) bus.RspReady = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] prev;
      bit          ghost;
      n_checks     = 0;
      n_errors     = 0;
      model_last   = 1'b1;
      ResetN       = 1'b0;
      bus.ReqValid = 2'b11;
      bus.RspReady = 2'b00;
      scramble();
      #3;
      check("rst_req_ready", 64'(bus.ReqReady), 64'd0);
      check("rst_rsp_valid", 64'(bus.RspValid), 64'd0);
      check("rst_rsp_result", 64'(bus.RspResult), 64'd0);
      check("rst_rsp_status", 64'(bus.RspStatus), 64'd0);
      check("rst_alu_a", 64'(AluA), 64'd0);
      check("rst_alu_b", 64'(AluB), 64'd0);
      check("rst_alu_f", 64'(AluFunc), 64'd0);
      check("rst_busy", 64'(Busy), 64'd0);
      @(negedge Clock);
      @(negedge Clock);
      ResetN = 1'b1;

      // Directed cases: plain add, signed overflow, status masking on OR.
      set_ops(0, 32'd5, 32'd7, 3'b000);
      do_op(2'b01, 1'b0, 0, 1'b0);
      check("add_result_const", 64'(bus.RspResult), 64'd12);
      set_ops(1, 32'h7FFF_FFFF, 32'd1, 3'b000);
      do_op(2'b10, 1'b0, 0, 1'b0);
      check("ovf_status_const", 64'(bus.RspStatus), 64'h9);
      set_ops(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b011);
      do_op(2'b01, 1'b0, 0, 1'b0);
      check("or_result_const", 64'(bus.RspResult), 64'hFFFF_FFFF);
      check("or_status_const", 64'(bus.RspStatus), 64'h0);

      // Backpressure for ten cycles.
      set_ops(1, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
      do_op(2'b10, 1'b0, 10, 1'b0);

      // Held tie with responses always accepted: 0,1,0,1 at the minimum interval.
      prev = 64'd0;
      for (int i = 0; i < 4; i++) begin
         set_ops(0, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
         set_ops(1, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
         do_op(2'b11, 1'b1, 0, 1'b1);
         check("tie_grant", 64'(model_last), 64'(i % 2));
         if (i > 0) check("tie_interval", t_accept - prev, 64'd40);
         prev = t_accept;
      end
      bus.ReqValid = 2'b00;
      bus.RspReady = 2'b00;

      // Reset during CAPTURE discards the operation.
      set_ops(0, rnd_word(), rnd_word(), 3'b000);
      bus.ReqValid = 2'b01;
      @(posedge Clock);
      #1;
      bus.ReqValid = 2'b00;
      @(negedge Clock);
      @(negedge Clock);
      check("midrst_state", 64'(dbg_state), 64'd2);
      ResetN       = 1'b0;
      bus.ReqValid = 2'b11;
      #1;
      check("midrst_rsp_valid", 64'(bus.RspValid), 64'd0);
      check("midrst_busy", 64'(Busy), 64'd0);
      check("midrst_req_ready", 64'(bus.ReqReady), 64'd0);
      check("midrst_alu_a", 64'(AluA), 64'd0);
      bus.ReqValid = 2'b00;
      model_last   = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      ResetN       = 1'b1;
      bus.RspReady = 2'b11;
      ghost        = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (bus.RspValid != 2'b00 || Busy) ghost = 1'b1;
      end
      check("midrst_no_rsp", 64'(ghost), 64'd0);
      set_ops(0, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
      set_ops(1, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
      do_op(2'b11, 1'b0, 0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         bit hr;
         set_ops(0, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
         set_ops(1, rnd_word(), rnd_word(), 3'($urandom_range(0, 7)));
         hr = 1'($urandom_range(0, 1));
         do_op(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
               hr ? 0 : $urandom_range(0, 3), hr);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
